// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg_pkg;

  // Per-slot phase: anodes dark (anti-ghost) then the digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_t;

  // Everything dark (all outputs are active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low g..a glyphs, indexed by nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Active-low one-cold anode select for a digit index.
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-low 7-segment glyph (g..a); purely combinational.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = GLYPH[nib];

endmodule

// File: rtl/seg_scan_ctl.sv
// 4-digit multiplexed 7-segment scan controller with a one-deep
// valid/ready input buffer. Each digit slot is SCAN_DIV cycles: BLANK_CYC
// dark cycles followed by the lit phase. New values are swapped in only at
// the start of a frame so a frame never mixes two values.
// Optional build macro SEG_LZB_EN: leading-zero blanking of digits 3..1.
module seg_scan_ctl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam logic [15:0] SLOT_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

  // scan state
  state_t      state_q, state_n;
  logic [1:0]  idx_q, idx_n;
  logic [15:0] cnt_q, cnt_n;
  logic        en_q;

  // input buffer and displayed value
  logic            pend_full;
  logic [3:0][3:0] pend_val;
  logic [3:0]      pend_dp;
  logic [3:0][3:0] act_val, act_val_n;
  logic [3:0]      act_dp, act_dp_n;

  logic       restart, wrap, xfer, load;
  logic [3:0] nib;
  logic [6:0] glyph;
  logic       lz_dark;
  logic [7:0] seg_n;
  logic [3:0] an_n;
  logic       frame_done_n;

  assign value_ready = !pend_full;
  assign xfer        = value_valid && !pend_full;

  // Enable rising restarts at digit-0 BLANK; the end of digit 3 wraps there.
  // Both are "frame start" edges where the pending value is promoted.
  assign restart = enable && !en_q;
  assign wrap    = enable && en_q && (state_q == ON) && (idx_q == 2'd3) &&
                   (cnt_q == SLOT_LAST);
  assign load    = (restart || wrap) && pend_full;

  // Next scan position: slot counter runs 0..SCAN_DIV-1, BLANK owns the first
  // BLANK_CYC counts; disabled or restarting parks at digit-0 BLANK, count 0.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    if (!enable || restart) begin
      state_n = BLANK;
      idx_n   = 2'd0;
      cnt_n   = 16'd0;
    end else begin
      cnt_n = (cnt_q == SLOT_LAST) ? 16'd0 : cnt_q + 16'd1;
      if (state_q == BLANK && cnt_q == BLANK_LAST) begin
        state_n = ON;
      end else if (state_q == ON && cnt_q == SLOT_LAST) begin
        state_n = BLANK;
        idx_n   = idx_q + 2'd1;
      end
    end
  end

  // Value seen by the next phase (already promoted on a frame-start edge).
  always_comb begin
    act_val_n = act_val;
    act_dp_n  = act_dp;
    if (load) begin
      act_val_n = pend_val;
      act_dp_n  = pend_dp;
    end
  end

  assign nib = act_val_n[idx_n];

  seg_decode u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

`ifdef SEG_LZB_EN
  // A digit above 0 goes dark when it and all higher nibbles are zero and
  // its own decimal point is off; slot timing is untouched.
  always_comb begin
    lz_dark = 1'b0;
    case (idx_n)
      2'd3: lz_dark = (act_val_n[3] == 4'h0) && !act_dp_n[3];
      2'd2: lz_dark = (act_val_n[3] == 4'h0) && (act_val_n[2] == 4'h0) &&
                      !act_dp_n[2];
      2'd1: lz_dark = (act_val_n[3] == 4'h0) && (act_val_n[2] == 4'h0) &&
                      (act_val_n[1] == 4'h0) && !act_dp_n[1];
      default: lz_dark = 1'b0;
    endcase
  end
`else
  assign lz_dark = 1'b0;
`endif

  // Output values for the phase being entered, so the pins change on the
  // same edge as the FSM.
  always_comb begin
    seg_n        = SEG_OFF;
    an_n         = AN_OFF;
    frame_done_n = 1'b0;
    if (state_n == ON) begin
      seg_n = {~act_dp_n[idx_n], glyph};
      if (!lz_dark) an_n = an_sel(idx_n);
      frame_done_n = (idx_n == 2'd3) && (cnt_n == SLOT_LAST);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= 16'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      en_q    <= enable;
    end
  end

  // Pending buffer and active register; promotion and acceptance never
  // coincide since a full buffer deasserts ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_full <= 1'b0;
      pend_val  <= '0;
      pend_dp   <= 4'b0000;
      act_val   <= '0;
      act_dp    <= 4'b0000;
    end else begin
      act_val <= act_val_n;
      act_dp  <= act_dp_n;
      if (load) pend_full <= 1'b0;
      if (xfer) begin
        pend_full <= 1'b1;
        pend_val  <= value_in;
        pend_dp   <= dp_in;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_n;
      an         <= an_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctl.sv
// Directed bench for seg_scan_ctl at SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        value_valid;
  logic        value_ready;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int errs = 0;
  int chks = 0;

  seg_scan_ctl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until a frame_done cycle (at least one edge); bounded.
  task automatic sync_frame(input string nm);
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick();
      if (frame_done === 1'b1) seen = 1;
    end
    chks++;
    if (!seen) begin
      errs++;
      $display("FAIL %s sync: frame_done not seen within 80 cycles", nm);
    end
  endtask

  // Called in a frame_done cycle; checks the whole following frame.
  // An expected anode of F means the digit is dark and seg is not checked.
  task automatic check_frame(input string nm, input logic [3:0][3:0] ea,
                             input logic [3:0][7:0] es, output logic rdy0);
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_fd;
    rdy0 = 1'bx;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        if (d == 0 && c == 0) rdy0 = value_ready;
        exp_an  = (c < 2) ? 4'hF : ea[d];
        exp_seg = (c < 2) ? 8'hFF : es[d];
        exp_fd  = (d == 3 && c == 7);
        chks++;
        if (an !== exp_an) begin
          errs++;
          $display("FAIL %s an d%0d c%0d: got %h want %h", nm, d, c, an, exp_an);
        end
        if (exp_an != 4'hF || c < 2) begin
          chks++;
          if (seg !== exp_seg) begin
            errs++;
            $display("FAIL %s seg d%0d c%0d: got %h want %h", nm, d, c, seg, exp_seg);
          end
        end
        chks++;
        if (frame_done !== exp_fd) begin
          errs++;
          $display("FAIL %s frame_done d%0d c%0d: got %b want %b", nm, d, c,
                   frame_done, exp_fd);
        end
      end
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    chks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; value_valid = 1'b0;
    value_in = 16'h0; dp_in = 4'h0;
    tick(); tick();
    chks++;
    if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0 || value_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset: an=%h seg=%h fd=%b rdy=%b want F FF 0 1",
               an, seg, frame_done, value_ready);
    end
    reset = 1'b1;
    tick();
    chks++;
    if (an !== 4'hF || seg !== 8'hFF || value_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_dark: an=%h seg=%h rdy=%b", an, seg, value_ready);
    end
  endtask

  task automatic test_basic();
    logic r0;
    enable = 1'b1;
    value_valid = 1'b1; value_in = 16'h1234; dp_in = 4'b0000;
    tick();
    value_valid = 1'b0;
    chk_bit("basic ready_after_xfer", value_ready, 1'b0);
    sync_frame("basic");
    // digit0..3 show nibbles 4,3,2,1
    check_frame("basic", {4'h7, 4'hB, 4'hD, 4'hE},
                {8'hF9, 8'hA4, 8'hB0, 8'h99}, r0);
    chk_bit("basic ready_at_frame_start", r0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic r0;
    tick(); tick(); tick();
    value_valid = 1'b1; value_in = 16'h5678; dp_in = 4'b0000;
    tick();
    value_in = 16'h9ABC; dp_in = 4'b1000;
    chk_bit("b2b ready_after_A", value_ready, 1'b0);
    tick(); tick(); tick();
    chk_bit("b2b ready_held", value_ready, 1'b0);
    sync_frame("b2b");
    chk_bit("b2b ready_at_frame_done", value_ready, 1'b0);
    check_frame("b2b A", {4'h7, 4'hB, 4'hD, 4'hE},
                {8'h92, 8'h82, 8'hF8, 8'h80}, r0);
    chk_bit("b2b ready_cycle_after_entry", r0, 1'b1);
    value_valid = 1'b0;
    chk_bit("b2b B_pending", value_ready, 1'b0);
    check_frame("b2b B", {4'h7, 4'hB, 4'hD, 4'hE},
                {8'h10, 8'h88, 8'h83, 8'hC6}, r0);
  endtask

  task automatic test_lzb();
    logic r0;
    value_valid = 1'b1; value_in = 16'h000F; dp_in = 4'b0100;
    tick();
    value_valid = 1'b0;
    sync_frame("lzb");
`ifdef SEG_LZB_EN
    check_frame("lzb", {4'hF, 4'hB, 4'hF, 4'hE},
                {8'hC0, 8'h40, 8'hC0, 8'h8E}, r0);
`else
    check_frame("lzb", {4'h7, 4'hB, 4'hD, 4'hE},
                {8'hC0, 8'h40, 8'hC0, 8'h8E}, r0);
`endif
  endtask

  task automatic test_enable_drop();
    bit bad = 0;
    sync_frame("en");
    for (int i = 0; i < 20; i++) tick();
    chks++;
    if (an !== 4'hB || seg !== 8'h40) begin
      errs++;
      $display("FAIL en digit2_on: an=%h seg=%h want B 40", an, seg);
    end
    enable = 1'b0;
    tick();
    chks++;
    if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
      errs++;
      $display("FAIL en drop: an=%h seg=%h fd=%b want F FF 0", an, seg, frame_done);
    end
    value_valid = 1'b1; value_in = 16'h4321; dp_in = 4'b0000;
    tick();
    value_valid = 1'b0;
    chk_bit("en handshake_while_off", value_ready, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) bad = 1;
    end
    chk_bit("en held_dark", bad, 1'b0);
    enable = 1'b1;
    tick();
    chks++;
    if (an !== 4'hF || seg !== 8'hFF || value_ready !== 1'b1) begin
      errs++;
      $display("FAIL en resume_blank0: an=%h seg=%h rdy=%b want F FF 1",
               an, seg, value_ready);
    end
    tick();
    chks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      errs++;
      $display("FAIL en resume_blank1: an=%h seg=%h want F FF", an, seg);
    end
    tick();
    chks++;
    if (an !== 4'hE || seg !== 8'hF9) begin
      errs++;
      $display("FAIL en first_lit: an=%h seg=%h want E F9", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    logic r0;
    for (int i = 0; i < 5; i++) tick();
    value_valid = 1'b1; value_in = 16'hFFFF; dp_in = 4'hF;
    tick();
    value_valid = 1'b0;
    chk_bit("rst_mid pending", value_ready, 1'b0);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chks++;
    if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0 || value_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid: an=%h seg=%h fd=%b rdy=%b want F FF 0 1",
               an, seg, frame_done, value_ready);
    end
    reset = 1'b1;
    sync_frame("rst_mid");
`ifdef SEG_LZB_EN
    check_frame("rst_mid f1", {4'hF, 4'hF, 4'hF, 4'hE},
                {8'hC0, 8'hC0, 8'hC0, 8'hC0}, r0);
    check_frame("rst_mid f2", {4'hF, 4'hF, 4'hF, 4'hE},
                {8'hC0, 8'hC0, 8'hC0, 8'hC0}, r0);
`else
    check_frame("rst_mid f1", {4'h7, 4'hB, 4'hD, 4'hE},
                {8'hC0, 8'hC0, 8'hC0, 8'hC0}, r0);
    check_frame("rst_mid f2", {4'h7, 4'hB, 4'hD, 4'hE},
                {8'hC0, 8'hC0, 8'hC0, 8'hC0}, r0);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_lzb();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
